// File: rtl/freq_lock_controller.sv
// freq_lock_controller
//   Closed-loop sequencer for a programmable clock divider. Loads an initial
//   divisor, lets the divider settle, measures one high pulse of psi in clk
//   cycles and nudges the divisor by one step toward set_period. After LOCK_N
//   consecutive in-tolerance measurements it declares lock and keeps tracking.
//
// Optional feature: define FLC_TIMEOUT_EN to enable a watchdog that aborts to
//   IDLE (and raises the sticky timeout flag) after TIMEOUT cycles spent
//   continuously waiting for / measuring a pulse. Without it, timeout is 0.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        one-cycle regulation request (honoured only in IDLE)
//   stop         abort to IDLE from any state
//   psi          feedback pulse, synchronous to clk
//   set_period   target high-pulse width (sampled in EVAL)
//   init_div     divisor loaded on start
//   div          registered divisor to the divider
//   meas         last completed pulse width (saturating)
//   locked       lock indication
//   busy         high in every state except IDLE
//   sat_err      sticky: adjustment requested at a divisor limit
//   timeout      sticky watchdog flag
module freq_lock_controller #(
  parameter int unsigned DIV_W   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned LOCK_N  = 3,
  parameter int unsigned TOL     = 1,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             psi,
  input  logic [CNT_W-1:0] set_period,
  input  logic [DIV_W-1:0] init_div,
  output logic [DIV_W-1:0] div,
  output logic [CNT_W-1:0] meas,
  output logic             locked,
  output logic             busy,
  output logic             sat_err,
  output logic             timeout
);

  localparam int unsigned SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);

  localparam logic [SET_W-1:0]  SettleLast = SET_W'(SETTLE - 1);
  localparam logic [GOOD_W-1:0] GoodMax    = GOOD_W'(LOCK_N);
  localparam logic [GOOD_W-1:0] GoodOne    = GOOD_W'(1);
  localparam logic [CNT_W-1:0]  CntMax     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CntOne     = CNT_W'(1);
  localparam logic [DIV_W-1:0]  DivMax     = {DIV_W{1'b1}};
  localparam logic [DIV_W-1:0]  DivOne     = DIV_W'(1);
  localparam logic [CNT_W:0]    TolExt     = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W:0]    ZeroExt    = '0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StArm,
    StMeasure,
    StEval
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   meas_q, meas_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic               locked_q, locked_d;
  logic               sat_q, sat_d;
  logic               psi_prev_q;
  logic               rise;

  // Signed-by-extension difference between the last measurement and target.
  logic [CNT_W:0]     diff;
  logic [CNT_W:0]     abs_diff;
  logic               in_tol;
  logic               too_short;

`ifdef FLC_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WdLast = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WdOne  = WD_W'(1);
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               tmo_q, tmo_d;
`endif

  assign rise      = psi & ~psi_prev_q;
  assign diff      = {1'b0, meas_q} - {1'b0, set_period};
  assign abs_diff  = diff[CNT_W] ? (ZeroExt - diff) : diff;
  assign in_tol    = (abs_diff <= TolExt);
  assign too_short = diff[CNT_W];

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    meas_d   = meas_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    good_d   = good_q;
    locked_d = locked_q;
    sat_d    = sat_q;
`ifdef FLC_TIMEOUT_EN
    wd_d     = '0;
    tmo_d    = tmo_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StLoad;
          sat_d   = 1'b0;
          good_d  = '0;
`ifdef FLC_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      StLoad: begin
        div_d    = init_div;
        locked_d = 1'b0;
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == SettleLast) begin
          state_d = StArm;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      StArm: begin
        // The rise cycle itself is the first counted high cycle.
        if (rise) begin
          cnt_d   = CntOne;
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        if (psi) begin
          if (cnt_q != CntMax) cnt_d = cnt_q + CntOne;
        end else begin
          meas_d  = cnt_q;
          state_d = StEval;
        end
      end
      StEval: begin
        if (in_tol) begin
          if (good_q != GoodMax) good_d = good_q + GoodOne;
          if (good_q >= GoodMax - GoodOne) locked_d = 1'b1;
          state_d = StArm;
        end else begin
          good_d   = '0;
          locked_d = 1'b0;
          settle_d = '0;
          if (too_short) begin
            // Pulse too short: a larger divisor lengthens it.
            if (div_q != DivMax) begin
              div_d   = div_q + DivOne;
              state_d = StSettle;
            end else begin
              sat_d   = 1'b1;
              state_d = StArm;
            end
          end else begin
            if (div_q != '0) begin
              div_d   = div_q - DivOne;
              state_d = StSettle;
            end else begin
              sat_d   = 1'b1;
              state_d = StArm;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef FLC_TIMEOUT_EN
    // Watchdog runs only while continuously in ARM/MEASURE.
    if (state_q == StArm || state_q == StMeasure) begin
      if (wd_q == WdLast) begin
        tmo_d    = 1'b1;
        locked_d = 1'b0;
        good_d   = '0;
        meas_d   = meas_q;
        state_d  = StIdle;
      end else begin
        wd_d = wd_q + WdOne;
      end
    end
`endif

    // Abort has priority over everything except reset; outputs hold.
    if (stop && state_q != StIdle) begin
      state_d  = StIdle;
      div_d    = div_q;
      meas_d   = meas_q;
      sat_d    = sat_q;
      locked_d = 1'b0;
      good_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      meas_q     <= '0;
      cnt_q      <= '0;
      settle_q   <= '0;
      good_q     <= '0;
      locked_q   <= 1'b0;
      sat_q      <= 1'b0;
      psi_prev_q <= 1'b0;
`ifdef FLC_TIMEOUT_EN
      wd_q       <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      meas_q     <= meas_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
      sat_q      <= sat_d;
      psi_prev_q <= psi;
`ifdef FLC_TIMEOUT_EN
      wd_q       <= wd_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign div     = div_q;
  assign meas    = meas_q;
  assign locked  = locked_q;
  assign busy    = (state_q != StIdle);
  assign sat_err = sat_q;
`ifdef FLC_TIMEOUT_EN
  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_freq_lock_controller.sv
// Scoreboard bench for freq_lock_controller: the stimulus process issues psi
// pulses and pushes the reference model's predicted result; a monitor pops and
// compares once the controller has evaluated each completed pulse.
module tb_freq_lock_controller;

  localparam int DIV_W   = 4;
  localparam int CNT_W   = 8;
  localparam int SETTLE  = 4;
  localparam int LOCK_N  = 3;
  localparam int TOL     = 1;
  localparam int TIMEOUT = 200;
  localparam int GAP     = SETTLE + 4;  // low cycles between pulses
  localparam int DIV_MAX = (1 << DIV_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FLC_TIMEOUT_EN
  localparam int LONG = 150;
`else
  localparam int LONG = 300;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             psi = 1'b0;
  logic [CNT_W-1:0] set_period = '0;
  logic [DIV_W-1:0] init_div = '0;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] meas;
  logic             locked, busy, sat_err, timeout;

  freq_lock_controller #(
    .DIV_W(DIV_W), .CNT_W(CNT_W), .SETTLE(SETTLE), .LOCK_N(LOCK_N), .TOL(TOL),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .psi(psi),
    .set_period(set_period), .init_div(init_div), .div(div), .meas(meas),
    .locked(locked), .busy(busy), .sat_err(sat_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int meas;
    int div;
    int locked;
    int sat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int m_div = 0, m_good = 0, m_locked = 0, m_sat = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_pulse(input int w, input int sp);
    exp_t e;
    int   m, d;
    m = (w > CNT_MAX) ? CNT_MAX : w;
    d = m - sp;
    if (d <= TOL && -d <= TOL) begin
      if (m_good < LOCK_N) m_good++;
      if (m_good == LOCK_N) m_locked = 1;
    end else begin
      m_good   = 0;
      m_locked = 0;
      if (m < sp) begin
        if (m_div < DIV_MAX) m_div++;
        else m_sat = 1;
      end else begin
        if (m_div > 0) m_div--;
        else m_sat = 1;
      end
    end
    e.meas = m; e.div = m_div; e.locked = m_locked; e.sat = m_sat;
    q.push_back(e);
  endfunction

  task automatic do_start(input int idiv);
    @(negedge clk);
    init_div = DIV_W'(idiv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_div = idiv; m_good = 0; m_locked = 0; m_sat = 0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    m_locked = 0; m_good = 0;
  endtask

  // Called at a negedge with psi low; leaves psi low for 'gap' cycles.
  task automatic pulse(input int w, input int sp, input int gap);
    set_period = CNT_W'(sp);
    model_pulse(w, sp);
    psi = 1'b1;
    repeat (w) @(negedge clk);
    psi = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: a fall of psi seen at a posedge means MEASURE->EVAL there; the
  // EVAL update lands one edge later.
  initial begin
    bit   prev;
    bit   p;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      p = psi;
      if (prev && !p && !rst && q.size() > 0) begin
        e = q.pop_front();
        @(posedge clk);
        @(negedge clk);
        chk("meas", int'(meas), e.meas);
        chk("div", int'(div), e.div);
        chk("locked", int'(locked), e.locked);
        chk("sat_err", int'(sat_err), e.sat);
        chk("busy_run", int'(busy), 1);
        prev = 1'b0;
      end else begin
        prev = p;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit");
  end

  initial begin
    int sp, w, r;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_div", int'(div), 0);
    chk("rst_meas", int'(meas), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sat", int'(sat_err), 0);
    chk("rst_timeout", int'(timeout), 0);

    // Converge upward from 5, then lock on three good pulses.
    do_start(5);
    chk("start_div", int'(div), 5);
    chk("start_busy", int'(busy), 1);
    pulse(6, 10, GAP);
    pulse(6, 10, GAP);
    repeat (3) pulse(10, 10, GAP);
    chk("lock1", int'(locked), 1);
    // Tolerance edges keep lock; just outside drops it.
    pulse(11, 10, GAP);
    pulse(9, 10, GAP);
    pulse(14, 10, GAP);
    repeat (3) pulse(10, 10, GAP);
    chk("relock", int'(locked), 1);
    // Out of tolerance by TOL+1, then abort while settling.
    pulse(12, 10, 2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    m_locked = 0; m_good = 0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_div", int'(div), m_div);
    chk("stop_locked", int'(locked), 0);

    // Divisor limits.
    do_start(15);
    pulse(3, 10, GAP);
    pulse(3, 10, GAP);
    chk("satmax_busy", int'(busy), 1);
    do_stop();
    do_start(0);
    chk("start_clears_sat", int'(sat_err), 0);
    pulse(20, 10, GAP);
    do_stop();

    // Long pulse saturates the counter.
    do_start(9);
    pulse(LONG, 10, GAP);
    do_stop();

    // Randomised tracking.
    do_start($urandom_range(DIV_MAX, 0));
    sp = $urandom_range(20, 5);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7, 0) == 0) sp = $urandom_range(20, 5);
      r = $urandom_range(9, 0);
      if (r < 6) w = sp + $urandom_range(2 * TOL, 0) - TOL;
      else w = $urandom_range(30, 1);
      pulse(w, sp, GAP);
    end
    do_stop();

    // Reset in the middle of a measurement.
    do_start(6);
    psi = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_div = 0; m_good = 0; m_locked = 0; m_sat = 0;
    chk("rstm_busy", int'(busy), 0);
    chk("rstm_div", int'(div), 0);
    chk("rstm_meas", int'(meas), 0);
    chk("rstm_locked", int'(locked), 0);
    psi = 1'b0;
    repeat (GAP) @(negedge clk);
    do_start(3);
    pulse(10, 10, GAP);
    pulse(4, 10, GAP);

    // No pulses at all: watchdog behaviour.
    do_stop();
    do_start(4);
    repeat (TIMEOUT + 50) @(negedge clk);
`ifdef FLC_TIMEOUT_EN
    chk("wd_busy", int'(busy), 0);
    chk("wd_timeout", int'(timeout), 1);
`else
    chk("wd_busy", int'(busy), 1);
    chk("wd_timeout", int'(timeout), 0);
`endif
    chk("wd_div", int'(div), 4);
    chk("wd_locked", int'(locked), 0);
    do_stop();

    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_lock_controller.md
Name: freq_lock_controller

Overview:
Closed-loop sequencer for a programmable clock divider driven by pulse-width feedback. It loads an initial divisor, waits for the divider to settle, then measures one high pulse of psi in clk cycles. It steps the divisor up or down toward set_period, repeating until LOCK_N consecutive in-tolerance measurements declare lock. It then keeps tracking and sits between the host configuration registers and the divider.

Parameters:
DIV_W, 4, divisor width
CNT_W, 8, pulse-width counter / set_period width
SETTLE, 4, clk cycles waited after any divisor change before arming (>=1)
LOCK_N, 3, consecutive in-tolerance measurements required for lock (>=1)
TOL, 1, allowed |meas - set_period| counted as in-tolerance
TIMEOUT, 200, watchdog limit in clk cycles (used only with FLC_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin regulation; ignored unless IDLE
stop  in  1  abort; returns to IDLE next cycle from any state
psi  in  1  feedback pulse, already synchronous to clk
set_period  in  CNT_W  target high-pulse width in clk cycles; sampled in EVAL
init_div  in  DIV_W  divisor loaded on start
div  out  DIV_W  divisor to divider (registered)
meas  out  CNT_W  last completed pulse width
locked  out  1  lock indication
busy  out  1  high in every state except IDLE
sat_err  out  1  sticky: adjustment requested at divisor limit
timeout  out  1  sticky watchdog flag (0 when feature compiled out)

Behaviour:
- Reset (synchronous, rst high at posedge clk): state=IDLE, div=0, meas=0, locked=0, busy=0, sat_err=0, timeout=0, psi_prev=0, good_cnt=0, all counters 0. Reset overrides stop/start; applies mid-measurement and discards partial count.
- psi_prev registers psi every cycle (including IDLE); rise = !psi_prev & psi; fall = psi_prev & !psi.
- IDLE: busy=0. start -> LOAD; sat_err, timeout, good_cnt cleared on start.
- LOAD (1 cycle): div<=init_div, locked<=0 -> SETTLE.
- SETTLE: counts SETTLE cycles, then -> ARM. Rise events during SETTLE are ignored.
- ARM: waits for rise; on rise -> MEASURE with count=1 (rise cycle counted).
- MEASURE: each cycle psi=1, count+1, saturating at 2^CNT_W-1 (no wrap). First cycle psi=0 -> EVAL; meas<=count at this transition.
- EVAL (1 cycle), d = meas vs set_period, unsigned, CNT_W+1-bit difference:
  - |d|<=TOL: good_cnt+1 (saturating at LOCK_N); when good_cnt reaches LOCK_N, locked<=1; div unchanged -> ARM (no settle needed).
  - meas<set_period-TOL: good_cnt<=0, locked<=0; if div<2^DIV_W-1, div+1 -> SETTLE; else sat_err<=1, div held -> ARM.
  - meas>set_period+TOL: good_cnt<=0, locked<=0; if div>0, div-1 -> SETTLE; else sat_err<=1, div held -> ARM.
- Lock is held while in tolerance; the first out-of-tolerance EVAL drops locked in that same cycle's update.
- stop: any non-IDLE state -> IDLE next cycle; div and meas hold; locked<=0; good_cnt<=0. stop and start together in IDLE: stop wins (remain IDLE).
- set_period change mid-run takes effect at the next EVAL only.
- Latency: start to first div update = 1 cycle; start to first EVAL >= 2+SETTLE+pulse width cycles.

Optional Feature:
FLC_TIMEOUT_EN. Defined: watchdog counts cycles spent continuously in ARM+MEASURE and clears on EVAL entry. On reaching TIMEOUT: timeout<=1 (sticky until next start), locked<=0, good_cnt<=0, state -> IDLE, div held. Not defined: no watchdog; ARM/MEASURE wait indefinitely; timeout tied 0.

Test Plan:
- Reset mid-MEASURE with psi high -> next cycle state IDLE, div=0, meas=0, busy=0, locked=0; later start works normally.
- init_div=5, set_period=10, psi pulses of 6 clk high -> div steps 6,7,... each after SETTLE; when pulses become 10 for three rounds -> locked=1 on third EVAL, div stable.
- Locked at div=8, one pulse of 14 (set 10, TOL 1) -> locked=0, div=7, good_cnt reset; three 10-cycle pulses -> relock.
- init_div=15, pulses of 3 (set 10) -> sat_err=1, div stays 15, busy stays 1; init_div=0 with pulses of 20 -> sat_err=1, div stays 0.
- psi held high 300 cycles -> meas=255 (saturated), div decrements; stop asserted during SETTLE -> IDLE next cycle, div held, locked=0.
- FLC_TIMEOUT_EN, TIMEOUT=200, psi held low after start -> 200 cycles in ARM then timeout=1, state IDLE, busy=0; without macro -> busy stays 1, timeout=0.
